// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation/release controller: all-or-nothing rename grants, two-port free merge, recovery sequencing.
// Grant is combinational; frees register once (T+1 to free list, counted T+2); squash lanes back-pressure via sq_free_rdy.
module preg_alloc_ctrl #(
  parameter int PREGS     = 48,
  parameter int ARCH_REGS = 32,
  parameter int TAGW      = 6,
  parameter int CNTW      = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ren_req,
  output logic              ren_grant,
  output logic              ren_stall,
  output logic [1:0]        alloc_en,
  input  logic [1:0]        cmt_free_vld,
  input  logic [2*TAGW-1:0] cmt_free_tag,
  input  logic [1:0]        sq_free_vld,
  input  logic [2*TAGW-1:0] sq_free_tag,
  output logic [1:0]        sq_free_rdy,
  input  logic              recover_start,
  input  logic              recover_done,
  output logic [1:0]        free_en,
  output logic [2*TAGW-1:0] free_phys,
  output logic [CNTW-1:0]   free_count,
  output logic              in_recovery,
  output logic              err_ovf
);

  localparam logic [CNTW-1:0] MAX_FREE = CNTW'(PREGS - ARCH_REGS);

  typedef enum logic [1:0] {RUN, RECOVER, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     count_q;
  logic [CNTW:0]       count_sum;
  logic [1:0]          free_en_q;
  logic [2*TAGW-1:0]   free_phys_q;
  logic                err_q;
  logic [1:0]          n_req, n_alloc, n_freed, n_cmt;
  logic                sq_window;
  logic [3:0]          cand_vld;
  logic [3:0][TAGW-1:0] cand_tag;
  logic [1:0]          slot_en;
  logic [2*TAGW-1:0]   slot_phys;
  logic [1:0]          slot_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // recover_start restarts the walk from any state and beats recover_done
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = RUN;
      RECOVER: if (recover_done) state_d = DRAIN;
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (recover_start) state_d = RECOVER;
  end

  assign n_req     = {1'b0, ren_req[0]} + {1'b0, ren_req[1]};
  assign ren_grant = !reset && (state_q == RUN) && (n_req != 2'd0) &&
                     (count_q >= {{(CNTW-2){1'b0}}, n_req});
  assign ren_stall = (|ren_req) && !ren_grant;
  assign alloc_en  = ren_req & {2{ren_grant}};

  // Commit owns the slots first; squash lanes take whatever is left, lane0 before lane1
  assign n_cmt          = {1'b0, cmt_free_vld[0]} + {1'b0, cmt_free_vld[1]};
  assign sq_window      = !reset && (state_q == RECOVER);
  assign sq_free_rdy[0] = sq_window && (n_cmt < 2'd2);
  assign sq_free_rdy[1] = sq_window && ((n_cmt + {1'b0, sq_free_vld[0]}) < 2'd2);

  assign cand_vld = {sq_free_vld & sq_free_rdy, cmt_free_vld};
  assign cand_tag = {sq_free_tag[TAGW +: TAGW], sq_free_tag[0 +: TAGW],
                     cmt_free_tag[TAGW +: TAGW], cmt_free_tag[0 +: TAGW]};

  always_comb begin
    slot_en   = 2'b00;
    slot_phys = '0;
    slot_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_vld[i]) begin
        if (slot_idx == 2'd0) begin
          slot_en[0]           = 1'b1;
          slot_phys[0 +: TAGW] = cand_tag[i];
        end else if (slot_idx == 2'd1) begin
          slot_en[1]              = 1'b1;
          slot_phys[TAGW +: TAGW] = cand_tag[i];
        end
        slot_idx = slot_idx + 2'd1;
      end
    end
  end

  assign n_alloc   = {1'b0, alloc_en[0]} + {1'b0, alloc_en[1]};
  assign n_freed   = {1'b0, free_en_q[0]} + {1'b0, free_en_q[1]};
  assign count_sum = {1'b0, count_q} - {{(CNTW-1){1'b0}}, n_alloc}
                                     + {{(CNTW-1){1'b0}}, n_freed};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_en_q   <= 2'b00;
      free_phys_q <= '0;
      count_q     <= MAX_FREE;
      err_q       <= 1'b0;
    end else begin
      free_en_q   <= slot_en;
      free_phys_q <= slot_phys;
      if (count_sum > {1'b0, MAX_FREE}) begin
        count_q <= MAX_FREE;
        err_q   <= 1'b1;
      end else begin
        count_q <= count_sum[CNTW-1:0];
      end
    end
  end

  assign free_en     = free_en_q;
  assign free_phys   = free_phys_q;
  assign free_count  = count_q;
  assign in_recovery = (state_q != RUN);
  assign err_ovf     = err_q;

endmodule

// File: doc/preg_alloc_ctrl.md
# preg_alloc_ctrl

Allocation/release controller in front of the physical-register free list. It grants rename-stage allocation requests all-or-nothing against a tracked free count. It merges commit-time releases and recovery-walk releases onto the free list's two free ports. It sequences branch-misprediction recovery so that no allocation occurs while squashed tags are being returned.

## Interface
Parameters:
- PREGS, core_pkg::PREGS (48): physical register count
- ARCH_REGS, core_pkg::ARCH_REGS (32): registers mapped at reset, not free
- TAGW, 6: physical tag width
- CNTW, 7: free-count width; must hold 0..PREGS

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ren_req  in  2  rename lanes requesting a tag; lane1 set only with lane0
- ren_grant  out  1  combinational; whole request granted this cycle
- ren_stall  out  1  combinational; |ren_req && !ren_grant
- alloc_en  out  2  to free list; ren_req & {2{ren_grant}}
- cmt_free_vld  in  2  commit releasing old tag, per lane
- cmt_free_tag  in  2×TAGW  tags released by commit
- sq_free_vld  in  2  recovery walk releasing squashed new tag
- sq_free_tag  in  2×TAGW  squashed tags
- sq_free_rdy  out  2  combinational; lane accepted this cycle
- recover_start  in  1  pulse; misprediction recovery begins
- recover_done  in  1  pulse; ROB walk has presented its last squash
- free_en  out  2  registered; to free list
- free_phys  out  2×TAGW  registered; to free list
- free_count  out  CNTW  registered tracked free tags
- in_recovery  out  1  registered; state != RUN
- err_ovf  out  1  sticky; count would exceed PREGS-ARCH_REGS... see Operation

## Operation
- FSM states: RUN, RECOVER, DRAIN. Reset → RUN.
- RUN → RECOVER on recover_start. RECOVER → DRAIN on recover_done. DRAIN → RUN after exactly one cycle, which empties the free_en register. recover_start in any state forces RECOVER; it wins over a simultaneous recover_done.
- Grant requires state == RUN. Let n = popcount(ren_req). ren_grant = (state==RUN) && n!=0 && free_count_q >= n. Same-cycle frees are never credited to a grant.
- Free-port arbitration uses 2 output slots, filled in order: cmt lane0, cmt lane1, sq lane0, sq lane1. Commit always fits, since commit is at most 2. sq_free_rdy[i] = (state==RECOVER) && a slot remains for it after the commit lanes and any lower sq lane. The sq interface is a valid/ready handshake; the producer holds the tag until ready.
- Selected slots are registered into free_en/free_phys. Slot 0 takes the first winner, slot 1 the second. Unused slots get free_en=0 and free_phys=0.
- Count update each edge: count_d = count_q − popcount(alloc_en) + popcount(free_en_q). The subtraction applies only to granted lanes, so it cannot underflow.
- If count_d > PREGS−ARCH_REGS, set err_ovf (sticky until reset) and saturate the count at PREGS−ARCH_REGS.
- Tags below ARCH_REGS are legal to free, because mappings migrate. No duplicate checking is done.

## Timing
- Reset values:
  - state RUN, free_count = PREGS−ARCH_REGS (16)
  - free_en 0, free_phys 0, in_recovery 0, err_ovf 0
  - ren_grant and sq_free_rdy evaluate to 0 while reset is held
- Allocation: alloc_en is asserted in cycle T. The free list returns alloc_phys/alloc_valid at T+1. free_count reflects the allocation at T+1.
- Release: a tag is accepted in cycle T and appears on free_en/free_phys at T+1. The free list applies it at the T+1 edge. free_count includes it from T+2.
- recover_start at T: grants are blocked from T+1 through the cycle DRAIN exits. in_recovery is high from T+1 until RUN is re-entered.
- Reset mid-recovery discards pending free_en. The free list is reset concurrently.

## Test plan
- Reset then ren_req=11 each cycle, no frees → 8 grants; free_count 16→0; ren_stall=1 on the 9th request; alloc_en=00.
- free_count=1, ren_req=11 → ren_grant=0 and alloc_en=00. Next cycle ren_req=01 → granted; count becomes 0.
- cmt_free_vld=11 (tags 40,41) with sq_free_vld=11 in RECOVER → sq_free_rdy=00. Next cycle free_en=11 with free_phys={41,40}.
- cmt_free_vld=01 tag 33, sq lane0 tag 45 and lane1 tag 46 in RECOVER → sq_free_rdy=01. Next free_en=11 with {45,33}. Tag 46 goes out the following cycle.
- recover_start, 3 squash tags, recover_done → in_recovery high 1 cycle after start through DRAIN; no grants during that window; count +3; RUN restored.
- free_count=16 with one extra commit free → err_ovf=1; count stays 16. Then assert reset mid-RECOVER → all outputs return to reset values asynchronously.
